// File: rtl/button_gesture.sv
// button_gesture: classifies a debounced button level into single, double and long-press pulses.
module button_gesture #(
  parameter int LONG_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 7_500_000,
  parameter int CW = $clog2((LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES) + 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pb_d,
  output logic       single_1p,
  output logic       double_1p,
  output logic       long_1p,
  output logic [1:0] last_event,
  output logic       busy
);
  typedef enum logic [2:0] {ARM, IDLE, PRESS1, WAIT2, PRESS2, HELD} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0] ev_nx;
  logic long_hit, gap_hit;
  assign long_hit = cnt == CW'(LONG_CYCLES - 1);
  assign gap_hit  = cnt == CW'(GAP_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARM;
      cnt        <= '0;
      single_1p  <= 1'b0;
      double_1p  <= 1'b0;
      long_1p    <= 1'b0;
      last_event <= 2'b00;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      single_1p  <= ev_nx == 2'b01;
      double_1p  <= ev_nx == 2'b10;
      long_1p    <= ev_nx == 2'b11;
      last_event <= (ev_nx != 2'b00) ? ev_nx : last_event;
    end
  end
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ARM:    state_nx = pb_d ? ARM : IDLE;
      IDLE: begin
        state_nx = pb_d ? PRESS1 : IDLE;
        cnt_nx   = '0;
      end
      PRESS1: begin
        state_nx = !pb_d ? WAIT2 : long_hit ? HELD : PRESS1;
        cnt_nx   = !pb_d ? '0 : cnt + 1'b1;
      end
      WAIT2: begin
        state_nx = pb_d ? PRESS2 : gap_hit ? IDLE : WAIT2;
        cnt_nx   = cnt + 1'b1;
      end
      PRESS2: state_nx = pb_d ? PRESS2 : IDLE;
      HELD:   state_nx = pb_d ? HELD : IDLE;
      default: state_nx = ARM;
    endcase
  end
  // Event code matches last_event encoding; 00 means no pulse this edge.
  always_comb begin
    busy  = state != IDLE;
    ev_nx = (state == PRESS1 && pb_d && long_hit) ? 2'b11 :
            (state == WAIT2 && !pb_d && gap_hit)  ? 2'b01 :
            (state == PRESS2 && !pb_d)            ? 2'b10 : 2'b00;
  end
endmodule

// File: tb/tb_button_gesture.sv
// tb_button_gesture: random and directed gestures checked against a run-length gesture model.
module tb_button_gesture;
  localparam int LONG = 8;
  localparam int GAP  = 4;
  logic clk, rst_n, pb_d;
  logic single_1p, double_1p, long_1p, busy;
  logic [1:0] last_event;
  int n_chk, n_pass;
  bit pbv[$];
  int ev[];
  bit idle[];
  int n, k, t0, t1, t3, e, len, gap, idle_from, exp_last, acc;

  button_gesture #(.LONG_CYCLES(LONG), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .pb_d(pb_d),
    .single_1p(single_1p), .double_1p(double_1p), .long_1p(long_1p),
    .last_event(last_event), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic add(input bit v, input int cnt);
    repeat (cnt) pbv.push_back(v);
  endtask

  function automatic logic [5:0] outv();
    return {single_1p, double_1p, long_1p, last_event, busy};
  endfunction

  initial begin
    n_chk = 0;
    n_pass = 0;
    add(1, 10); add(0, 20);
    add(1, 3);  add(0, 10);
    add(1, 20); add(0, 10);
    add(1, 8);  add(0, 10);
    add(1, 2);  add(0, 4); add(1, 3); add(0, 10);
    for (int i = 0; i < 80; i++) begin
      add(1, $urandom_range(1, 12));
      add(0, ($urandom_range(0, 5) == 0) ? 10 : $urandom_range(1, 7));
    end
    add(0, 30);
    n = pbv.size() - 20;
    ev = new[pbv.size()];
    idle = new[pbv.size()];
    k = 0;
    while (pbv[k]) k++;
    idle_from = k;
    k++;
    while (k < n) begin
      while (k < n && !pbv[k]) k++;
      if (k >= n) begin
        for (int j = idle_from; j < n; j++) idle[j] = 1;
        break;
      end
      t0 = k;
      for (int j = idle_from; j < t0; j++) idle[j] = 1;
      len = 0;
      while (pbv[t0 + len]) len++;
      if (len >= LONG + 1) begin
        ev[t0 + LONG] = 3;
        e = t0 + len;
      end else begin
        t1 = t0 + len;
        gap = 0;
        while (gap <= GAP && !pbv[t1 + gap]) gap++;
        if (gap > GAP) begin
          ev[t1 + GAP] = 1;
          e = t1 + GAP;
        end else begin
          t3 = t1 + gap;
          while (pbv[t3]) t3++;
          ev[t3] = 2;
          e = t3;
        end
      end
      idle_from = e;
      k = e + 1;
    end

    rst_n = 1'b0;
    pb_d = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("reset", outv(), 6'b000001);
    @(negedge clk) rst_n = 1'b1;
    exp_last = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk) pb_d = pbv[i];
      @(posedge clk);
      #1;
      if (ev[i] != 0) exp_last = ev[i];
      check($sformatf("cyc%0d", i), outv(),
            {ev[i] == 1, ev[i] == 2, ev[i] == 3, exp_last[1:0], !idle[i]});
    end

    @(negedge clk) pb_d = 1'b1;
    @(negedge clk) pb_d = 1'b1;
    @(negedge clk) pb_d = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("wait2_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("async_rst", outv(), 6'b000001);
    @(negedge clk) rst_n = 1'b1;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 acc = acc | single_1p | double_1p | long_1p | last_event;
    end
    check("post_rst_quiet", acc, 0);
    check("post_rst_idle", busy, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
